// File: rtl/rc4_engine_if.sv
// rtl/rc4_engine_if.sv - RC4 engine control, S RAM, ciphertext ROM and plaintext RAM bus
`timescale 1ns/1ps
interface rc4_engine_if #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
);
    localparam int MSG_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

    logic                   start;
    logic [8*KEY_BYTES-1:0] secret_key;
    logic                   busy;
    logic                   done;
    logic                   fail;
    logic [7:0]             s_address;
    logic [7:0]             s_data;
    logic                   s_wren;
    logic [7:0]             s_q;
    logic [MSG_AW-1:0]      rom_address;
    logic [7:0]             rom_q;
    logic [MSG_AW-1:0]      d_address;
    logic [7:0]             d_data;
    logic                   d_wren;

    modport master (
        output start, secret_key, s_q, rom_q,
        input  busy, done, fail, s_address, s_data, s_wren,
               rom_address, d_address, d_data, d_wren
    );

    modport slave (
        input  start, secret_key, s_q, rom_q,
        output busy, done, fail, s_address, s_data, s_wren,
               rom_address, d_address, d_data, d_wren
    );
endinterface

// File: rtl/rc4_engine.sv
// rtl/rc4_engine.sv - RC4 decryptor (KSA + PRGA) over external S RAM; RC4_VALID_CHECK_EN adds plaintext check
`timescale 1ns/1ps
module rc4_engine #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_LEN   = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    rc4_engine_if.slave  bus
);
    localparam int MSG_AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] INIT = 3'd1;
    localparam logic [2:0] KSA  = 3'd2;
    localparam logic [2:0] PRGA = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]             state;
    logic [2:0]             step;
    logic [7:0]             i, j, si, sj;
    logic [MSG_AW-1:0]      k;
    logic [8*KEY_BYTES-1:0] key_r;
    logic                   fail_r;

    logic [7:0] key_byte, j_ksa, j_prga, plain;
    logic       byte_ok;

    // The key register rotates one byte per KSA step, so its top byte is always key[i mod KEY_BYTES].
    assign key_byte = key_r[8*KEY_BYTES-1 -: 8];
    assign j_ksa    = j + bus.s_q + key_byte;
    assign j_prga   = j + bus.s_q;
    assign plain    = bus.s_q ^ bus.rom_q;

`ifdef RC4_VALID_CHECK_EN
    assign byte_ok = ((plain >= 8'h61) && (plain <= 8'h7a)) || (plain == 8'h20);
`else
    assign byte_ok = 1'b1;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            step   <= 3'd0;
            i      <= 8'd0;
            j      <= 8'd0;
            si     <= 8'd0;
            sj     <= 8'd0;
            k      <= '0;
            key_r  <= '0;
            fail_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    key_r  <= bus.secret_key;
                    fail_r <= 1'b0;
                    i      <= 8'd0;
                    state  <= INIT;
                end
                INIT: begin
                    i <= i + 8'd1;
                    if (i == 8'hff) begin
                        state <= KSA;
                        step  <= 3'd0;
                        j     <= 8'd0;
                    end
                end
                KSA: begin
                    step <= step + 3'd1;
                    if (step == 3'd1) begin
                        si    <= bus.s_q;
                        j     <= j_ksa;
                        key_r <= (key_r << 8) | (key_r >> (8*(KEY_BYTES-1)));
                    end
                    if (step == 3'd4) begin
                        step <= 3'd0;
                        i    <= i + 8'd1;
                        if (i == 8'hff) begin
                            state <= PRGA;
                            j     <= 8'd0;
                            k     <= '0;
                        end
                    end
                end
                PRGA: begin
                    step <= step + 3'd1;
                    case (step)
                        3'd0: i <= i + 8'd1;
                        3'd1: begin
                            si <= bus.s_q;
                            j  <= j_prga;
                        end
                        3'd3: sj <= bus.s_q;
                        3'd6: begin
                            step <= 3'd0;
                            if (!byte_ok) begin
                                fail_r <= 1'b1;
                                state  <= DONE;
                            end else if (k == K_LAST) begin
                                state <= DONE;
                            end else begin
                                k <= k + 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                DONE: begin
                    state <= IDLE;
                    i     <= 8'd0;
                    j     <= 8'd0;
                    k     <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Swap is read S[i], read S[j], write S[i]=S[j], write S[j]=old S[i]; with i==j both writes restore S[i].
    always_comb begin
        bus.s_address   = 8'd0;
        bus.s_data      = 8'd0;
        bus.s_wren      = 1'b0;
        bus.d_wren      = 1'b0;
        bus.d_data      = 8'd0;
        bus.d_address   = '0;
        bus.rom_address = '0;
        case (state)
            INIT: begin
                bus.s_address = i;
                bus.s_data    = i;
                bus.s_wren    = 1'b1;
            end
            KSA, PRGA: begin
                case (step)
                    3'd0: bus.s_address = (state == PRGA) ? i + 8'd1 : i;
                    3'd2: bus.s_address = j;
                    3'd3: begin
                        bus.s_address = i;
                        bus.s_data    = bus.s_q;
                        bus.s_wren    = 1'b1;
                    end
                    3'd4: begin
                        bus.s_address = j;
                        bus.s_data    = si;
                        bus.s_wren    = 1'b1;
                    end
                    3'd5: bus.s_address = (state == PRGA) ? si + sj : 8'd0;
                    default: ;
                endcase
                if (state == PRGA) begin
                    bus.rom_address = k;
                    if (step == 3'd6 && byte_ok) begin
                        bus.d_wren    = 1'b1;
                        bus.d_address = k;
                        bus.d_data    = plain;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.busy = (state == INIT) || (state == KSA) || (state == PRGA);
    assign bus.done = (state == DONE);
    assign bus.fail = fail_r;
endmodule
